ahb_sram_slave: RTL and testbench
=================================

Name: ahb_sram_slave

Overview:
- AHB slave (responder) fronting an on-chip word-organised SRAM. It answers single transfers issued by the core's AHB master interfaces (instruction and data ports) through the bus arbiter/decoder.
- Handles address/data phase pipelining, programmable wait states, byte-lane writes, and the two-cycle ERROR response for illegal accesses.
- Sits behind the address decoder; the decoder drives HSEL.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte base address of the SRAM window
- MEM_DEPTH, 1024, number of 32-bit words; must be a power of two
- WAIT_STATES, 0, HREADYOUT-low cycles inserted per OKAY data phase (0..7)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- HSEL  in  1  slave select from decoder
- HADDR  in  32  byte address
- HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- HSIZE  in  3  000 byte, 001 halfword, 010 word
- HBURST  in  3  ignored; every beat is handled as a single transfer
- HWRITE  in  1  1 write, 0 read
- HWDATA  in  32  write data, valid in the data phase
- HREADY  in  1  bus-wide ready (previous data phase completing)
- HREADYOUT  out  1  this slave's data-phase ready
- HRESP  out  2  00 OKAY, 01 ERROR
- HRDATA  out  32  read data

Behaviour:
- Reset: state IDLE, HREADYOUT=1, HRESP=00, HRDATA=0, all address-phase registers cleared. SRAM contents are not reset.
- Address phase accept: HSEL & HTRANS[1] & HREADY at a rising edge. The slave then registers addr_q, size_q, write_q and enters the data phase.
- Not accepted: HTRANS IDLE/BUSY or HSEL=0. No data phase starts; the slave stays in or returns to IDLE with OKAY, zero-wait.
- Legality check at accept; a transfer is illegal if any of the following holds:
  - HSIZE > 010
  - halfword with HADDR[0]=1
  - word with HADDR[1:0]≠00
  - (HADDR−BASE_ADDR)>>2 ≥ MEM_DEPTH, or HADDR < BASE_ADDR
- State machine:
  - IDLE: HREADYOUT=1, HRESP=00. On legal accept go to WAIT if WAIT_STATES>0, else to DATA. On illegal accept go to ERR1.
  - WAIT: HREADYOUT=0, HRESP=00. A wait counter loads WAIT_STATES−1 on entry and decrements; go to DATA when it reaches 0.
  - DATA: HREADYOUT=1, HRESP=00; the transfer completes at this edge.
    - Write: commit HWDATA byte lanes into mem[addr_q] at this edge.
    - A new accept in the same cycle (pipelined) goes to WAIT, DATA or ERR1 as from IDLE; otherwise go to IDLE.
  - ERR1: HREADYOUT=0, HRESP=01; next state ERR2.
  - ERR2: HREADYOUT=1, HRESP=01. No memory update. Handle a pipelined accept as in DATA; otherwise go to IDLE.
- Byte lanes (little-endian), selected by addr_q[1:0] and size_q:
  - byte → lane addr[1:0]
  - halfword → lanes {addr[1],0} and {addr[1],1}
  - word → all four lanes
  - Unselected lanes keep their old contents.
- HRDATA:
  - In DATA for a read: the full word mem[addr_q], combinational from storage; the master extracts the lanes it needs.
  - At all other times, including WAIT, error states and write phases: 0.
- Read-after-write: a read whose address phase overlaps the previous write's DATA cycle returns the newly written data with zero wait states. This holds because the write commits at that edge and the read's data phase follows it.
- HWDATA is sampled only in the DATA cycle of a write; the value during WAIT is ignored.
- HREADY low without a completing data phase: no new accept occurs; in-flight state is unaffected.
- Reset asserted mid-operation (WAIT/ERR1): return immediately to the reset values; a pending write is dropped.

Test Plan:
- WAIT_STATES=0: write word 0xDEADBEEF to 0x0000_0010, then read it → write DATA cycle HREADYOUT=1, HRESP=00; read HRDATA=0xDEADBEEF in the cycle after its address phase.
- Preload word 0x11223344 at 0x20, then halfword write 0xABCD to 0x22 → readback 0xABCD3344; byte write 0x55 to 0x21 → readback 0xABCD5544.
- WAIT_STATES=2: single read → HREADYOUT low for exactly 2 cycles and high on the 3rd, with HRDATA valid only in that cycle.
- Word access to 0x0000_0006, HSIZE=011, and an address ≥ BASE_ADDR+4*MEM_DEPTH (each) → ERR1 (HREADYOUT=0, HRESP=01), then ERR2 (HREADYOUT=1, HRESP=01); memory unchanged.
- Back-to-back write 0xCAFEF00D to 0x40 followed immediately by a pipelined read of 0x40 → read data phase returns 0xCAFEF00D with no stall; HTRANS=IDLE beats with HSEL=1 → OKAY, zero-wait, memory unchanged.
- rst driven low during WAIT of a write (WAIT_STATES=3) → HREADYOUT=1, HRESP=00, HRDATA=0 immediately; target word keeps its old value.

Source files
------------

// File: rtl/ahb_sram_slave.sv
// AHB single-transfer responder in front of a word-organised SRAM.
// Supports programmable wait states, byte-lane writes and the two-cycle ERROR response.
module ahb_sram_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned MEM_DEPTH   = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP,
  output logic [31:0] HRDATA
);

  localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int unsigned OFS_W = IDX_W + 2;
  localparam int unsigned CNT_W = 3;
  localparam logic [1:0]  RESP_OKAY  = 2'b00;
  localparam logic [1:0]  RESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t             state;
  logic [OFS_W-1:0]   addr_q;
  logic [2:0]         size_q;
  logic               write_q;
  logic [CNT_W-1:0]   wait_cnt;

  logic [31:0]        mem [MEM_DEPTH];

  logic               accept_c;
  logic [31:0]        offset_c;
  logic               in_range_c;
  logic               aligned_c;
  logic               legal_c;
  logic [3:0]         lane_en_c;
  logic [IDX_W-1:0]   word_idx_c;
  logic               unused_c;

  // Burst type and SEQ/NONSEQ distinction do not change how a beat is served.
  assign unused_c = ^{HBURST, HTRANS[0]};

  // Address-phase qualification and legality.
  assign accept_c   = HSEL & HTRANS[1] & HREADY;
  assign offset_c   = HADDR - BASE_ADDR;
  assign in_range_c = (HADDR >= BASE_ADDR) && ((offset_c >> 2) < 32'(MEM_DEPTH));
  assign legal_c    = in_range_c & aligned_c;

  always_comb begin
    aligned_c = 1'b0;
    case (HSIZE)
      3'b000:  aligned_c = 1'b1;
      3'b001:  aligned_c = ~HADDR[0];
      3'b010:  aligned_c = (HADDR[1:0] == 2'b00);
      default: aligned_c = 1'b0;
    endcase
  end

  // Little-endian byte-lane enables for the registered transfer.
  always_comb begin
    lane_en_c = 4'b0000;
    case (size_q)
      3'b000:  lane_en_c = 4'b0001 << addr_q[1:0];
      3'b001:  lane_en_c = addr_q[1] ? 4'b1100 : 4'b0011;
      3'b010:  lane_en_c = 4'b1111;
      default: lane_en_c = 4'b0000;
    endcase
  end

  assign word_idx_c = addr_q[OFS_W-1:2];

  // Transfer FSM; HREADYOUT/HRESP are registered alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      HREADYOUT <= 1'b1;
      HRESP     <= RESP_OKAY;
      addr_q    <= '0;
      size_q    <= '0;
      write_q   <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      case (state)
        ST_WAIT: begin
          if (wait_cnt == '0) begin
            state     <= ST_DATA;
            HREADYOUT <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end
        end
        ST_ERR1: begin
          state     <= ST_ERR2;
          HREADYOUT <= 1'b1;
          HRESP     <= RESP_ERROR;
        end
        default: begin
          // IDLE, DATA and ERR2 all leave the bus ready, so a new address phase may land here.
          if (accept_c) begin
            addr_q  <= offset_c[OFS_W-1:0];
            size_q  <= HSIZE;
            write_q <= HWRITE;
            if (!legal_c) begin
              state     <= ST_ERR1;
              HREADYOUT <= 1'b0;
              HRESP     <= RESP_ERROR;
            end else if (WAIT_STATES > 0) begin
              state     <= ST_WAIT;
              HREADYOUT <= 1'b0;
              HRESP     <= RESP_OKAY;
              wait_cnt  <= CNT_W'(WAIT_STATES - 1);
            end else begin
              state     <= ST_DATA;
              HREADYOUT <= 1'b1;
              HRESP     <= RESP_OKAY;
            end
          end else begin
            state     <= ST_IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= RESP_OKAY;
          end
        end
      endcase
    end
  end

  // Write commit on the completing data cycle; unselected lanes keep their contents.
  always_ff @(posedge clk) begin
    if (state == ST_DATA && write_q) begin
      if (lane_en_c[0]) mem[word_idx_c][7:0]   <= HWDATA[7:0];
      if (lane_en_c[1]) mem[word_idx_c][15:8]  <= HWDATA[15:8];
      if (lane_en_c[2]) mem[word_idx_c][23:16] <= HWDATA[23:16];
      if (lane_en_c[3]) mem[word_idx_c][31:24] <= HWDATA[31:24];
    end
  end

  // Full word straight from storage during a read data cycle, zero otherwise.
  assign HRDATA = (state == ST_DATA && !write_q) ? mem[word_idx_c] : 32'h0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Self-checking bench for ahb_sram_slave: three instances (0, 2 and 3 wait states)
// exercised by directed scenarios and a randomized pipelined stream against a word-array model.
module tb_ahb_sram_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic        hwrite;
  logic [31:0] hwdata;
  logic        hready;
  logic [2:0]  hreadyout;
  logic [1:0]  hresp [3];
  logic [31:0] hrdata [3];
  logic [1:0]  tgt;

  int checks = 0;
  int failures = 0;

  logic [31:0] mdl [3][16];

  always #5 clk = ~clk;

  assign hready = hreadyout[tgt];

  ahb_sram_slave #(.BASE_ADDR(32'h0000_0000), .MEM_DEPTH(1024), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst), .HSEL(hsel[0]), .HADDR(haddr), .HTRANS(htrans), .HSIZE(hsize),
    .HBURST(hburst), .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(hready),
    .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]), .HRDATA(hrdata[0]));

  ahb_sram_slave #(.BASE_ADDR(32'h0000_1000), .MEM_DEPTH(256), .WAIT_STATES(2)) u_ws2 (
    .clk(clk), .rst(rst), .HSEL(hsel[1]), .HADDR(haddr), .HTRANS(htrans), .HSIZE(hsize),
    .HBURST(hburst), .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(hready),
    .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]), .HRDATA(hrdata[1]));

  ahb_sram_slave #(.BASE_ADDR(32'h0000_0000), .MEM_DEPTH(1024), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst(rst), .HSEL(hsel[2]), .HADDR(haddr), .HTRANS(htrans), .HSIZE(hsize),
    .HBURST(hburst), .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(hready),
    .HREADYOUT(hreadyout[2]), .HRESP(hresp[2]), .HRDATA(hrdata[2]));

  function automatic int ws_of(input logic [1:0] di);
    case (di)
      2'd1:    return 2;
      2'd2:    return 3;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] base_of(input logic [1:0] di);
    return (di == 2'd1) ? 32'h0000_1000 : 32'h0000_0000;
  endfunction

  function automatic int unsigned depth_of(input logic [1:0] di);
    return (di == 2'd1) ? 256 : 1024;
  endfunction

  // Legality straight from the access rules.
  function automatic bit legal(input logic [31:0] a, input logic [2:0] sz,
                               input logic [31:0] base, input int unsigned depth);
    if (sz > 3'd2) return 1'b0;
    if (sz == 3'd1 && a[0]) return 1'b0;
    if (sz == 3'd2 && a[1:0] != 2'b00) return 1'b0;
    if (a < base) return 1'b0;
    if (((a - base) >> 2) >= depth) return 1'b0;
    return 1'b1;
  endfunction

  // One non-pipelined transfer; returns what the bus showed during its data phase.
  task automatic do_xfer(input logic [1:0] di, input logic [31:0] a, input logic [2:0] sz,
                         input logic wr, input logic [31:0] wd, output int nlow,
                         output logic [1:0] rsp0, output logic [1:0] rspn,
                         output logic [31:0] rd, output bit bad_low);
    int guard;
    tgt = di;
    @(posedge clk); #1;
    hsel = '0; hsel[di] = 1'b1; htrans = 2'b10; haddr = a; hsize = sz; hwrite = wr;
    hwdata = $urandom;
    @(posedge clk); #1;
    hsel = '0; htrans = 2'b00; haddr = $urandom; hwrite = 1'($urandom); hwdata = $urandom;
    nlow = 0; bad_low = 1'b0; guard = 0; rd = '0; rsp0 = 2'b11; rspn = 2'b11;
    forever begin
      @(negedge clk);
      if (guard == 0) rsp0 = hresp[di];
      if (hreadyout[di]) begin
        rspn = hresp[di]; rd = hrdata[di]; hwdata = wd;
        break;
      end
      nlow++;
      if (hrdata[di] !== 32'h0) bad_low = 1'b1;
      guard++;
      if (guard > 20) begin
        nlow = 999;
        break;
      end
      @(posedge clk);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({hreadyout[i], hresp[i], hrdata[i]} !== {1'b1, 2'b00, 32'h0}) begin
        failures++;
        $display("FAIL reset[%0d]: ready=%b resp=%b rdata=%h, want 1/00/0", i, hreadyout[i], hresp[i], hrdata[i]);
      end
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_word_rw();
    int nl; logic [1:0] r0, rn; logic [31:0] rd; bit bl;
    do_xfer(2'd0, 32'h10, 3'b010, 1'b1, 32'hDEAD_BEEF, nl, r0, rn, rd, bl);
    checks++;
    if (nl != 0 || rn !== 2'b00 || rd !== 32'h0) begin
      failures++;
      $display("FAIL word_write: waits=%0d resp=%b rdata=%h, want 0/00/0", nl, rn, rd);
    end
    do_xfer(2'd0, 32'h10, 3'b010, 1'b0, 32'h0, nl, r0, rn, rd, bl);
    checks++;
    if (nl != 0 || rn !== 2'b00) begin
      failures++;
      $display("FAIL word_read_timing: waits=%0d resp=%b, want 0/00", nl, rn);
    end
    checks++;
    if (rd !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL word_read_data: got %h want deadbeef", rd);
    end
  endtask

  task automatic test_byte_lanes();
    int nl; logic [1:0] r0, rn; logic [31:0] rd; bit bl;
    logic [31:0] junk;
    do_xfer(2'd0, 32'h20, 3'b010, 1'b1, 32'h1122_3344, nl, r0, rn, rd, bl);
    junk = $urandom;
    do_xfer(2'd0, 32'h22, 3'b001, 1'b1, {16'hABCD, junk[15:0]}, nl, r0, rn, rd, bl);
    do_xfer(2'd0, 32'h20, 3'b010, 1'b0, 32'h0, nl, r0, rn, rd, bl);
    checks++;
    if (rd !== 32'hABCD_3344) begin
      failures++;
      $display("FAIL halfword_lane: got %h want abcd3344", rd);
    end
    junk = $urandom;
    do_xfer(2'd0, 32'h21, 3'b000, 1'b1, {junk[31:16], 8'h55, junk[7:0]}, nl, r0, rn, rd, bl);
    do_xfer(2'd0, 32'h20, 3'b010, 1'b0, 32'h0, nl, r0, rn, rd, bl);
    checks++;
    if (rd !== 32'hABCD_5544) begin
      failures++;
      $display("FAIL byte_lane1: got %h want abcd5544", rd);
    end
    junk = $urandom;
    do_xfer(2'd0, 32'h23, 3'b000, 1'b1, {8'h99, junk[23:0]}, nl, r0, rn, rd, bl);
    do_xfer(2'd0, 32'h20, 3'b010, 1'b0, 32'h0, nl, r0, rn, rd, bl);
    checks++;
    if (rd !== 32'h99CD_5544) begin
      failures++;
      $display("FAIL byte_lane3: got %h want 99cd5544", rd);
    end
  endtask

  task automatic test_wait_states();
    int nl; logic [1:0] r0, rn; logic [31:0] rd, v; bit bl;
    v = $urandom;
    do_xfer(2'd1, 32'h1008, 3'b010, 1'b1, v, nl, r0, rn, rd, bl);
    checks++;
    if (nl != 2 || rn !== 2'b00) begin
      failures++;
      $display("FAIL ws2_write: waits=%0d resp=%b, want 2/00", nl, rn);
    end
    do_xfer(2'd1, 32'h1008, 3'b010, 1'b0, 32'h0, nl, r0, rn, rd, bl);
    checks++;
    if (nl != 2 || r0 !== 2'b00 || rn !== 2'b00 || bl) begin
      failures++;
      $display("FAIL ws2_read_timing: waits=%0d resp=%b/%b rdata_in_wait_nonzero=%0d, want 2/00/00/0", nl, r0, rn, bl);
    end
    checks++;
    if (rd !== v) begin
      failures++;
      $display("FAIL ws2_read_data: got %h want %h", rd, v);
    end
  endtask

  task automatic test_errors();
    int nl; logic [1:0] r0, rn; logic [31:0] rd; bit bl;
    logic [1:0]  e_di [6];
    logic [31:0] e_a  [6];
    logic [2:0]  e_sz [6];
    logic        e_wr [6];
    logic [31:0] keep_a [3];
    logic [31:0] keep_v [3];
    e_di = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1};
    e_a  = '{32'h6, 32'h10, 32'h1000, 32'h5, 32'hFFC, 32'h1400};
    e_sz = '{3'b010, 3'b011, 3'b010, 3'b001, 3'b010, 3'b010};
    e_wr = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    keep_a = '{32'h0, 32'h4, 32'h10};
    keep_v = '{32'hA5A5_0000, 32'h0404_0404, 32'h1010_1010};
    for (int i = 0; i < 3; i++)
      do_xfer(2'd0, keep_a[i], 3'b010, 1'b1, keep_v[i], nl, r0, rn, rd, bl);
    for (int i = 0; i < 6; i++) begin
      do_xfer(e_di[i], e_a[i], e_sz[i], e_wr[i], $urandom, nl, r0, rn, rd, bl);
      checks++;
      if (nl != 1 || r0 !== 2'b01 || rn !== 2'b01 || rd !== 32'h0) begin
        failures++;
        $display("FAIL error[%0d] addr=%h size=%b: lowcycles=%0d resp=%b/%b rdata=%h, want 1/01/01/0",
                 i, e_a[i], e_sz[i], nl, r0, rn, rd);
      end
    end
    for (int i = 0; i < 3; i++) begin
      do_xfer(2'd0, keep_a[i], 3'b010, 1'b0, 32'h0, nl, r0, rn, rd, bl);
      checks++;
      if (rd !== keep_v[i]) begin
        failures++;
        $display("FAIL error_mem_unchanged addr=%h: got %h want %h", keep_a[i], rd, keep_v[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int nl; logic [1:0] r0, rn; logic [31:0] rd; bit bl;
    do_xfer(2'd0, 32'h40, 3'b010, 1'b1, 32'h0BAD_0BAD, nl, r0, rn, rd, bl);
    tgt = 2'd0;
    @(posedge clk); #1;
    hsel = 3'b001; htrans = 2'b10; haddr = 32'h40; hsize = 3'b010; hwrite = 1'b1;
    @(posedge clk); #1;
    htrans = 2'b10; haddr = 32'h40; hsize = 3'b010; hwrite = 1'b0; hwdata = 32'hCAFE_F00D;
    @(negedge clk);
    checks++;
    if ({hreadyout[0], hresp[0]} !== 3'b100) begin
      failures++;
      $display("FAIL b2b_write_phase: ready=%b resp=%b, want 1/00", hreadyout[0], hresp[0]);
    end
    @(posedge clk); #1;
    hsel = '0; htrans = 2'b00; hwdata = $urandom;
    @(negedge clk);
    checks++;
    if ({hreadyout[0], hresp[0], hrdata[0]} !== {1'b1, 2'b00, 32'hCAFE_F00D}) begin
      failures++;
      $display("FAIL b2b_read_phase: ready=%b resp=%b rdata=%h, want 1/00/cafef00d", hreadyout[0], hresp[0], hrdata[0]);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      hsel = 3'b001; htrans = 2'(i % 2); haddr = 32'h40; hsize = 3'b010; hwrite = 1'b1; hwdata = 32'h0;
      @(negedge clk);
      checks++;
      if ({hreadyout[0], hresp[0], hrdata[0]} !== {1'b1, 2'b00, 32'h0}) begin
        failures++;
        $display("FAIL idle_beat[%0d]: ready=%b resp=%b rdata=%h, want 1/00/0", i, hreadyout[0], hresp[0], hrdata[0]);
      end
      @(posedge clk); #1;
    end
    hsel = '0; htrans = 2'b00;
    do_xfer(2'd0, 32'h40, 3'b010, 1'b0, 32'h0, nl, r0, rn, rd, bl);
    checks++;
    if (rd !== 32'hCAFE_F00D) begin
      failures++;
      $display("FAIL idle_mem_unchanged: got %h want cafef00d", rd);
    end
  endtask

  // Randomized pipelined stream against the word-array model.
  task automatic test_random(input logic [1:0] di, input int n);
    int ws, w, issued, cyc, k;
    int nl; logic [1:0] r0, rn; logic [31:0] rd; bit bl;
    logic [31:0] base, a_a, a_wd, d_a, d_wd, v;
    logic [2:0] a_sz, d_sz;
    logic [1:0] a_tr;
    logic [3:0] d_w;
    logic a_wr, d_wr, d_legal, rdy;
    bit a_act, a_hold, d_act;
    logic [34:0] got, exp;
    ws = ws_of(di); base = base_of(di);
    for (int i = 0; i < 16; i++) begin
      v = $urandom;
      do_xfer(di, base + 32'(4 * i), 3'b010, 1'b1, v, nl, r0, rn, rd, bl);
      mdl[di][i] = v;
    end
    tgt = di; issued = 0; cyc = 0; k = 0;
    d_act = 1'b0; a_act = 1'b0; a_hold = 1'b0;
    d_a = '0; d_wd = '0; d_sz = '0; d_wr = 1'b0; d_legal = 1'b0; d_w = '0;
    a_a = '0; a_wd = '0; a_sz = '0; a_wr = 1'b0; a_tr = 2'b10;
    @(posedge clk); #1;
    while ((issued < n || d_act) && cyc < 4000) begin
      if (!a_hold) begin
        a_act = (issued < n) && ($urandom_range(0, 3) != 0);
        if (a_act) begin
          w = $urandom_range(0, 15);
          a_sz = 3'($urandom_range(0, 2)); a_wr = 1'($urandom); a_wd = $urandom;
          a_tr = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b11;
          a_a = base + 32'(4 * w + $urandom_range(0, 3));
          if ($urandom_range(0, 3) != 0) begin
            if (a_sz == 3'd1) a_a[0] = 1'b0;
            if (a_sz == 3'd2) a_a[1:0] = 2'b00;
          end
          case ($urandom_range(0, 19))
            0:       a_a = base + 32'(4 * depth_of(di) + 4 * w);
            1:       a_sz = 3'($urandom_range(3, 7));
            2:       a_a = base - 32'(4 + 4 * w);
            default: ;
          endcase
        end
      end
      if (a_act) begin
        hsel = '0; hsel[di] = 1'b1; htrans = a_tr; haddr = a_a; hsize = a_sz; hwrite = a_wr;
      end else begin
        hsel = '0; hsel[di] = 1'($urandom); htrans = 2'($urandom_range(0, 1));
        haddr = $urandom; hsize = 3'($urandom); hwrite = 1'($urandom);
      end
      hwdata = $urandom;
      @(negedge clk);
      rdy = hreadyout[di];
      got = {hreadyout[di], hresp[di], hrdata[di]};
      if (!d_act)        exp = {1'b1, 2'b00, 32'h0};
      else if (!d_legal) exp = {(k != 0), 2'b01, 32'h0};
      else if (k < ws)   exp = {1'b0, 2'b00, 32'h0};
      else               exp = {1'b1, 2'b00, d_wr ? 32'h0 : mdl[di][d_w]};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL random[%0d] cyc=%0d ready/resp/rdata: got %h want %h", di, cyc, got, exp);
      end
      if (d_act && rdy && d_wr) hwdata = d_wd;
      @(posedge clk);
      if (d_act && rdy) begin
        if (d_legal && d_wr)
          for (int b = 0; b < 4; b++)
            if (b >= int'(d_a[1:0]) && b < int'(d_a[1:0]) + (1 << d_sz))
              mdl[di][d_w][8*b +: 8] = d_wd[8*b +: 8];
        d_act = 1'b0;
      end else if (d_act) begin
        k++;
      end
      if (a_act && rdy) begin
        d_act = 1'b1; k = 0; d_a = a_a; d_sz = a_sz; d_wr = a_wr; d_wd = a_wd;
        d_legal = legal(a_a, a_sz, base, depth_of(di));
        d_w = 4'((a_a - base) >> 2);
        issued++;
        a_act = 1'b0; a_hold = 1'b0;
      end else begin
        a_hold = a_act;
      end
      #1;
      cyc++;
    end
    hsel = '0; htrans = 2'b00;
    checks++;
    if (issued < n || d_act) begin
      failures++;
      $display("FAIL random[%0d]_timeout: issued %0d of %0d within cycle budget", di, issued, n);
    end
  endtask

  task automatic test_reset_midop();
    int nl; logic [1:0] r0, rn; logic [31:0] rd; bit bl;
    do_xfer(2'd2, 32'h80, 3'b010, 1'b1, 32'h1234_5678, nl, r0, rn, rd, bl);
    tgt = 2'd2;
    @(posedge clk); #1;
    hsel = 3'b100; htrans = 2'b10; haddr = 32'h80; hsize = 3'b010; hwrite = 1'b1;
    @(posedge clk); #1;
    hsel = '0; htrans = 2'b00; hwdata = 32'hFFFF_FFFF;
    @(negedge clk);
    checks++;
    if (hreadyout[2] !== 1'b0) begin
      failures++;
      $display("FAIL midop_in_wait: ready=%b want 0", hreadyout[2]);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({hreadyout[2], hresp[2], hrdata[2]} !== {1'b1, 2'b00, 32'h0}) begin
      failures++;
      $display("FAIL midop_reset: ready=%b resp=%b rdata=%h, want 1/00/0", hreadyout[2], hresp[2], hrdata[2]);
    end
    @(negedge clk);
    rst = 1'b1;
    do_xfer(2'd2, 32'h80, 3'b010, 1'b0, 32'h0, nl, r0, rn, rd, bl);
    checks++;
    if (nl != 3 || rd !== 32'h1234_5678) begin
      failures++;
      $display("FAIL midop_write_dropped: waits=%0d rdata=%h, want 3/12345678", nl, rd);
    end
  endtask

  initial begin
    rst = 1'b0; hsel = '0; haddr = '0; htrans = 2'b00; hsize = 3'b000; hburst = 3'b000;
    hwrite = 1'b0; hwdata = '0; tgt = 2'd0;
    test_reset();
    test_word_rw();
    test_byte_lanes();
    test_wait_states();
    test_errors();
    test_back_to_back();
    test_random(2'd0, 150);
    test_random(2'd1, 150);
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
